pc_next_ctrl: RTL and testbench

Next-PC generator and front-end hazard controller. It is the driver side of the program-counter register interface and produces NewPC, StopPC and Halt every cycle. It resolves EX-stage branches, ID-stage jumps, load-use hazards, memory-busy stalls and halt drain. It sits between the ID/EX pipeline registers and the PC register, and it drives the IF/ID and ID/EX flush and stall controls.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 21 ++
 rtl/pc_next_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_next_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared front-end pipeline types and constants for the next-PC controller.
package pipe_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INSTR_BYTES = 2;
  localparam int unsigned REG_IDX_W   = 4;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [2:0] {
    RUN,
    LU_STALL_S,
    MEM_WAIT,
    DRAIN,
    HALTED
  } state_e;

  // Sequential PC, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID source that reads the register a load in EX is writing.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 i_ld_ex,
  input  logic [REG_IDX_W-1:0] i_ld_rd_ex,
  input  logic [REG_IDX_W-1:0] i_id_rs,
  input  logic [REG_IDX_W-1:0] i_id_rt,
  input  logic                 i_id_uses_rs,
  input  logic                 i_id_uses_rt,
  output logic                 o_hz
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_id_uses_rs && (i_id_rs == i_ld_rd_ex);
  assign w_rt_match = i_id_uses_rt && (i_id_rt == i_ld_rd_ex);
  assign o_hz       = i_ld_ex && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC generator and front-end hazard controller: resolves branches, jumps,
// load-use bubbles, memory waits and halt drain, and drives the PC register.
module pc_next_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LU_STALL     = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_W-1:0]      PC,
  input  logic                 StayHalted,
  input  logic                 br_taken_ex,
  input  logic [PC_W-1:0]      br_target_ex,
  input  logic                 jmp_id,
  input  logic [PC_W-1:0]      jmp_target_id,
  input  logic                 halt_id,
  input  logic                 ld_ex,
  input  logic [REG_IDX_W-1:0] ld_rd_ex,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 mem_busy,
  output logic [PC_W-1:0]      NewPC,
  output logic                 StopPC,
  output logic                 Halt,
  output logic                 stall_ifid,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 hold_all,
  output logic                 halted_done
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;

  state_e             w_state_d;
  logic [CNT_W-1:0]   w_cnt_d;
  logic               w_hz;
  logic               w_run_eval;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_new_pc;
  logic               w_stop_pc;
  logic               w_halt;
  logic               w_stall_ifid;
  logic               w_flush_ifid;
  logic               w_flush_idex;
  logic               w_hold_all;
  logic               w_halted_done;

  hazard_detect u_hazard_detect (
    .i_ld_ex      (ld_ex),
    .i_ld_rd_ex   (ld_rd_ex),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .o_hz         (w_hz)
  );

  assign w_pc_inc = pc_inc(PC);

  // MEM_WAIT falls through to the RUN priorities in the cycle mem_busy drops.
  assign w_run_eval = (r_state == RUN) || ((r_state == MEM_WAIT) && !mem_busy);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_new_pc      = w_pc_inc;
    w_stop_pc     = 1'b0;
    w_halt        = 1'b0;
    w_stall_ifid  = 1'b0;
    w_flush_ifid  = 1'b0;
    w_flush_idex  = 1'b0;
    w_hold_all    = 1'b0;
    w_halted_done = 1'b0;

    if (w_run_eval) begin
      w_state_d = RUN;
      if (StayHalted) begin
        w_halt        = 1'b1;
        w_halted_done = 1'b1;
        w_state_d     = HALTED;
      end else if (mem_busy) begin
        w_stop_pc    = 1'b1;
        w_hold_all   = 1'b1;
        w_stall_ifid = 1'b1;
        w_state_d    = MEM_WAIT;
      end else if (br_taken_ex) begin
        w_new_pc     = br_target_ex;
        w_flush_ifid = 1'b1;
        w_flush_idex = 1'b1;
      end else if (w_hz) begin
        w_stop_pc    = 1'b1;
        w_stall_ifid = 1'b1;
        w_flush_idex = 1'b1;
        w_cnt_d      = CNT_W'(LU_STALL - 1);
        w_state_d    = (LU_STALL > 1) ? LU_STALL_S : RUN;
      end else if (jmp_id) begin
        w_new_pc     = jmp_target_id;
        w_flush_ifid = 1'b1;
      end else if (halt_id) begin
        w_halt       = 1'b1;
        w_flush_ifid = 1'b1;
        w_cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
        w_state_d    = (DRAIN_CYCLES > 1) ? DRAIN : HALTED;
      end
    end else begin
      unique case (r_state)
        LU_STALL_S: begin
          w_stop_pc    = 1'b1;
          w_stall_ifid = 1'b1;
          if (mem_busy) begin
            w_hold_all = 1'b1;
            w_cnt_d    = '0;
            w_state_d  = MEM_WAIT;
          end else begin
            w_flush_idex = 1'b1;
            w_cnt_d      = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) w_state_d = RUN;
          end
        end
        MEM_WAIT: begin
          w_stop_pc    = 1'b1;
          w_hold_all   = 1'b1;
          w_stall_ifid = 1'b1;
        end
        DRAIN: begin
          w_halt       = 1'b1;
          w_flush_ifid = 1'b1;
          if (mem_busy) begin
            w_hold_all = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) w_state_d = HALTED;
          end
        end
        HALTED: begin
          w_halt        = 1'b1;
          w_halted_done = 1'b1;
        end
        default: begin
          w_state_d = RUN;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Reset forces the controls quiet immediately, independent of the clock.
  assign NewPC       = rst ? w_new_pc : w_pc_inc;
  assign StopPC      = rst & w_stop_pc;
  assign Halt        = rst & w_halt;
  assign stall_ifid  = rst & w_stall_ifid;
  assign flush_ifid  = rst & w_flush_ifid;
  assign flush_idex  = rst & w_flush_idex;
  assign hold_all    = rst & w_hold_all;
  assign halted_done = rst & w_halted_done;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl with default parameters (LU_STALL=1, DRAIN_CYCLES=3).
module tb_pc_next_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] PC;
  logic        StayHalted;
  logic        br_taken_ex;
  logic [15:0] br_target_ex;
  logic        jmp_id;
  logic [15:0] jmp_target_id;
  logic        halt_id;
  logic        ld_ex;
  logic [3:0]  ld_rd_ex;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        mem_busy;
  logic [15:0] NewPC;
  logic        StopPC;
  logic        Halt;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        hold_all;
  logic        halted_done;

  int tests;
  int fails;

  // {NewPC, StopPC, Halt, stall_ifid, flush_ifid, flush_idex, hold_all, halted_done}
  logic [22:0] obs;
  assign obs = {NewPC, StopPC, Halt, stall_ifid, flush_ifid, flush_idex, hold_all, halted_done};

  pc_next_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .PC            (PC),
    .StayHalted    (StayHalted),
    .br_taken_ex   (br_taken_ex),
    .br_target_ex  (br_target_ex),
    .jmp_id        (jmp_id),
    .jmp_target_id (jmp_target_id),
    .halt_id       (halt_id),
    .ld_ex         (ld_ex),
    .ld_rd_ex      (ld_rd_ex),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .mem_busy      (mem_busy),
    .NewPC         (NewPC),
    .StopPC        (StopPC),
    .Halt          (Halt),
    .stall_ifid    (stall_ifid),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .hold_all      (hold_all),
    .halted_done   (halted_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StayHalted    = 1'b0;
    br_taken_ex   = 1'b0;
    br_target_ex  = 16'h0000;
    jmp_id        = 1'b0;
    jmp_target_id = 16'h0000;
    halt_id       = 1'b0;
    ld_ex         = 1'b0;
    ld_rd_ex      = 4'h0;
    id_rs         = 4'h0;
    id_rt         = 4'h0;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    mem_busy      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    PC = 16'h1234;
    br_taken_ex = 1'b1;
    br_target_ex = 16'h0100;
    halt_id = 1'b1;
    mem_busy = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h1236, 7'b0000000}) begin
      fails++;
      $display("FAIL reset_outputs: got %h want %h", obs, {16'h1236, 7'b0000000});
    end
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    #3;
    tests++;
    if (obs !== {16'h1236, 7'b0000000}) begin
      fails++;
      $display("FAIL reset_release_run: got %h want %h", obs, {16'h1236, 7'b0000000});
    end
  endtask

  task automatic test_increment();
    clear_inputs();
    PC = 16'h0010;
    #3;
    tests++;
    if (obs !== {16'h0012, 7'b0000000}) begin
      fails++;
      $display("FAIL inc_0010: got %h want %h", obs, {16'h0012, 7'b0000000});
    end
    step();
    PC = 16'hFFFE;
    #3;
    tests++;
    if (obs !== {16'h0000, 7'b0000000}) begin
      fails++;
      $display("FAIL inc_wrap: got %h want %h", obs, {16'h0000, 7'b0000000});
    end
    step();
    PC = 16'h0030;
    jmp_id = 1'b1;
    jmp_target_id = 16'h0200;
    #3;
    tests++;
    if (obs !== {16'h0200, 7'b0001000}) begin
      fails++;
      $display("FAIL jump: got %h want %h", obs, {16'h0200, 7'b0001000});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    PC = 16'h0020;
    ld_ex = 1'b1;
    ld_rd_ex = 4'd3;
    id_rs = 4'd3;
    id_uses_rs = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0022, 7'b1010100}) begin
      fails++;
      $display("FAIL lu_rs_stall: got %h want %h", obs, {16'h0022, 7'b1010100});
    end
    step();
    ld_ex = 1'b0;
    #3;
    tests++;
    if (obs !== {16'h0022, 7'b0000000}) begin
      fails++;
      $display("FAIL lu_cleared: got %h want %h", obs, {16'h0022, 7'b0000000});
    end
    step();
    // Matching index that is not actually read must not stall.
    ld_ex = 1'b1;
    id_uses_rs = 1'b0;
    #3;
    tests++;
    if (obs !== {16'h0022, 7'b0000000}) begin
      fails++;
      $display("FAIL lu_unused_rs: got %h want %h", obs, {16'h0022, 7'b0000000});
    end
    step();
    id_rs = 4'd1;
    id_rt = 4'd3;
    id_uses_rt = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0022, 7'b1010100}) begin
      fails++;
      $display("FAIL lu_rt_stall: got %h want %h", obs, {16'h0022, 7'b1010100});
    end
    step();
    id_rt = 4'd4;
    #3;
    tests++;
    if (obs !== {16'h0022, 7'b0000000}) begin
      fails++;
      $display("FAIL lu_rt_nomatch: got %h want %h", obs, {16'h0022, 7'b0000000});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    PC = 16'h0050;
    br_taken_ex = 1'b1;
    br_target_ex = 16'h0100;
    jmp_id = 1'b1;
    jmp_target_id = 16'h0200;
    halt_id = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0100, 7'b0001100}) begin
      fails++;
      $display("FAIL br_over_jmp_halt: got %h want %h", obs, {16'h0100, 7'b0001100});
    end
    step();
    clear_inputs();
    #3;
    tests++;
    if (obs !== {16'h0052, 7'b0000000}) begin
      fails++;
      $display("FAIL br_stays_run: got %h want %h", obs, {16'h0052, 7'b0000000});
    end
    step();
    br_taken_ex = 1'b1;
    br_target_ex = 16'h0400;
    ld_ex = 1'b1;
    ld_rd_ex = 4'd5;
    id_rs = 4'd5;
    id_uses_rs = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0400, 7'b0001100}) begin
      fails++;
      $display("FAIL br_over_hz: got %h want %h", obs, {16'h0400, 7'b0001100});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_halt_drain();
    clear_inputs();
    PC = 16'h0060;
    halt_id = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0062, 7'b0101000}) begin
      fails++;
      $display("FAIL halt_start: got %h want %h", obs, {16'h0062, 7'b0101000});
    end
    step();
    halt_id = 1'b0;
    br_taken_ex = 1'b1;
    br_target_ex = 16'h0100;
    #3;
    tests++;
    if (obs !== {16'h0062, 7'b0101000}) begin
      fails++;
      $display("FAIL drain_ignores_br: got %h want %h", obs, {16'h0062, 7'b0101000});
    end
    step();
    br_taken_ex = 1'b0;
    #3;
    tests++;
    if (obs !== {16'h0062, 7'b0101000}) begin
      fails++;
      $display("FAIL drain_cycle2: got %h want %h", obs, {16'h0062, 7'b0101000});
    end
    step();
    #3;
    tests++;
    if (obs !== {16'h0062, 7'b0100001}) begin
      fails++;
      $display("FAIL halted_done_c3: got %h want %h", obs, {16'h0062, 7'b0100001});
    end
    step();
    jmp_id = 1'b1;
    jmp_target_id = 16'h0700;
    #3;
    tests++;
    if (obs !== {16'h0062, 7'b0100001}) begin
      fails++;
      $display("FAIL halted_sticky: got %h want %h", obs, {16'h0062, 7'b0100001});
    end
    do_reset();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    PC = 16'h0040;
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      tests++;
      if (obs !== {16'h0042, 7'b1010010}) begin
        fails++;
        $display("FAIL mem_hold_c%0d: got %h want %h", i, obs, {16'h0042, 7'b1010010});
      end
      step();
    end
    mem_busy = 1'b0;
    #3;
    tests++;
    if (obs !== {16'h0042, 7'b0000000}) begin
      fails++;
      $display("FAIL mem_release: got %h want %h", obs, {16'h0042, 7'b0000000});
    end
    step();
    mem_busy = 1'b1;
    step();
    mem_busy = 1'b0;
    jmp_id = 1'b1;
    jmp_target_id = 16'h0300;
    #3;
    tests++;
    if (obs !== {16'h0300, 7'b0001000}) begin
      fails++;
      $display("FAIL mem_release_jmp: got %h want %h", obs, {16'h0300, 7'b0001000});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_drain();
    clear_inputs();
    PC = 16'h0080;
    halt_id = 1'b1;
    step();
    halt_id = 1'b0;
    step();
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (obs !== {16'h0082, 7'b0000000}) begin
      fails++;
      $display("FAIL rst_mid_drain: got %h want %h", obs, {16'h0082, 7'b0000000});
    end
    step();
    rst = 1'b1;
    step();
    #3;
    tests++;
    if (obs !== {16'h0082, 7'b0000000}) begin
      fails++;
      $display("FAIL rst_after_drain: got %h want %h", obs, {16'h0082, 7'b0000000});
    end
    step();
    #3;
    tests++;
    if (obs !== {16'h0082, 7'b0000000}) begin
      fails++;
      $display("FAIL rst_no_halt_resume: got %h want %h", obs, {16'h0082, 7'b0000000});
    end
    step();
  endtask

  task automatic test_stay_halted();
    clear_inputs();
    PC = 16'h0090;
    StayHalted = 1'b1;
    #3;
    tests++;
    if (obs !== {16'h0092, 7'b0100001}) begin
      fails++;
      $display("FAIL stay_halted: got %h want %h", obs, {16'h0092, 7'b0100001});
    end
    step();
    StayHalted = 1'b0;
    #3;
    tests++;
    if (obs !== {16'h0092, 7'b0100001}) begin
      fails++;
      $display("FAIL stay_halted_sticky: got %h want %h", obs, {16'h0092, 7'b0100001});
    end
    do_reset();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    PC = 16'h0000;
    clear_inputs();
    step();
    test_reset();
    step();
    test_increment();
    test_load_use();
    test_branch_priority();
    test_halt_drain();
    test_mem_wait();
    test_reset_mid_drain();
    test_stay_halted();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
